// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the 32-entry register file; winner is registered onto wr_*.
// Optional macro REGFILE_R0_ZERO_EN: grants to address 0 are accepted but never write register 0.
module regfile_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 wr_en,
    output logic [4:0]           wr_addr,
    output logic [31:0]          wr_data,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] win_idx;
    logic             win_found;
    logic             xfer;
    logic [4:0]       win_addr;
    logic [31:0]      win_data;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    // (p + k) mod NREQ, valid for p < NREQ and k <= NREQ
    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return PTR_W'(s);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) return c;
        return c + 1'b1;
    endfunction

    // Rotate-priority search starting at rr_ptr
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[rot_idx(rr_ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = rot_idx(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (win_found && !rst) gnt = NREQ'(1) << win_idx;
        xfer     = |gnt;
        win_addr = req_addr[int'(win_idx)*5 +: 5];
        win_data = req_data[int'(win_idx)*32 +: 32];
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = rot_idx(win_idx, 1);

        wr_en_d = xfer;
`ifdef REGFILE_R0_ZERO_EN
        if (win_addr == 5'd0) wr_en_d = 1'b0;
`else
`endif
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wr_en_d) begin
            wr_addr_d = win_addr;
            wr_data_d = win_data;
        end

        conflict_cnt_d = conflict_cnt_q;
        if ($countones(req) >= 2) conflict_cnt_d = sat_inc(conflict_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            conflict_cnt_q <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single request, round-robin, wrap/skip, R0, saturation, mid reset.
module tb_regfile_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   gnt, gnt4;
    logic         wr_en, wr_en4;
    logic [4:0]   wr_addr, wr_addr4;
    logic [31:0]  wr_data, wr_data4;
    logic [15:0]  conflict_cnt;
    logic [3:0]   conflict_cnt4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.NREQ(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .conflict_cnt(conflict_cnt)
    );

    regfile_wr_arbiter #(.NREQ(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .conflict_cnt(conflict_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    // Checks gnt for the current inputs, clocks once, then checks the registered write port
    task automatic grant_step(input string tag, input logic [3:0] exp_gnt,
                              input logic exp_en, input logic [4:0] exp_addr, input logic [31:0] exp_data);
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        tick();
        chk({tag, "_wr_en"}, 32'(wr_en), 32'(exp_en));
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(exp_addr));
        chk({tag, "_wr_data"}, wr_data, exp_data);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) set_lane(i, 5'(10 + i), 32'hA000_0000 + 32'(i));

        // Reset held two cycles with all requesters active
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_gnt_hold", 32'(gnt), 32'h0);
            chk("rst_wr_en", 32'(wr_en), 32'h0);
            chk("rst_wr_addr", 32'(wr_addr), 32'h0);
            chk("rst_wr_data", wr_data, 32'h0);
            chk("rst_cnt", 32'(conflict_cnt), 32'h0);
            chk("rst_cnt4", 32'(conflict_cnt4), 32'h0);
        end
        rst = 1'b0;

        // Round-robin across all four for 8 cycles
        grant_step("rr0", 4'b0001, 1'b1, 5'd10, 32'hA000_0000);
        grant_step("rr1", 4'b0010, 1'b1, 5'd11, 32'hA000_0001);
        grant_step("rr2", 4'b0100, 1'b1, 5'd12, 32'hA000_0002);
        grant_step("rr3", 4'b1000, 1'b1, 5'd13, 32'hA000_0003);
        grant_step("rr4", 4'b0001, 1'b1, 5'd10, 32'hA000_0000);
        grant_step("rr5", 4'b0010, 1'b1, 5'd11, 32'hA000_0001);
        grant_step("rr6", 4'b0100, 1'b1, 5'd12, 32'hA000_0002);
        grant_step("rr7", 4'b1000, 1'b1, 5'd13, 32'hA000_0003);
        chk("rr_cnt", 32'(conflict_cnt), 32'd8);

        // Single requester 2; rr_ptr is back at 0
        req = 4'b0100;
        set_lane(2, 5'd17, 32'hDEAD_BEEF);
        grant_step("single", 4'b0100, 1'b1, 5'd17, 32'hDEAD_BEEF);
        req = 4'b0000;
        grant_step("idle", 4'b0000, 1'b0, 5'd17, 32'hDEAD_BEEF);
        chk("single_cnt", 32'(conflict_cnt), 32'd8);

        // rr_ptr=3 now: wrap to 0, skip 1, then 2 back to back
        req = 4'b0101;
        grant_step("wrap0", 4'b0001, 1'b1, 5'd10, 32'hA000_0000);
        grant_step("skip2", 4'b0100, 1'b1, 5'd17, 32'hDEAD_BEEF);
        chk("wrap_cnt", 32'(conflict_cnt), 32'd10);
        req = 4'b0000;
        grant_step("idle2", 4'b0000, 1'b0, 5'd17, 32'hDEAD_BEEF);

        // Address 0 write from requester 1; rr_ptr=3 searches 3,0,1
        req = 4'b0010;
        set_lane(1, 5'd0, 32'h1234_5678);
`ifdef REGFILE_R0_ZERO_EN
        grant_step("r0", 4'b0010, 1'b0, 5'd17, 32'hDEAD_BEEF);
`else
        grant_step("r0", 4'b0010, 1'b1, 5'd0, 32'h1234_5678);
`endif

        // Grant to 3, then reset while it requests again
        req = 4'b1000;
        grant_step("pre_rst", 4'b1000, 1'b1, 5'd13, 32'hA000_0003);
        rst = 1'b1;
        grant_step("mid_rst", 4'b0000, 1'b0, 5'd0, 32'h0);
        chk("mid_rst_cnt", 32'(conflict_cnt), 32'h0);
        rst = 1'b0;
        grant_step("post_rst", 4'b1000, 1'b1, 5'd13, 32'hA000_0003);

        // 20 conflict cycles: 16-bit counter reaches 20, 4-bit counter sticks at 15
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 14) chk("sat_at15", 32'(conflict_cnt4), 32'd15);
        end
        chk("sat_cnt16", 32'(conflict_cnt), 32'd20);
        chk("sat_cnt4", 32'(conflict_cnt4), 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Round-robin arbiter and sequencer for the single write port of the 32-entry register file. Up to NREQ requesters present a 5-bit register address and a 32-bit data word. One request is granted per cycle, and the winner is registered onto the write port. The registered write address drives the 5-to-32 one-hot write-enable decoder, so the decoder sees a stable address for a full cycle.

## Interface
Parameters:
- NREQ, 4 — number of requesters; legal range 2..8.
- CNT_W, 16 — width of the conflict counter.

Ports:
- clk  in  1  — single clock; all state updates on its rising edge.
- rst  in  1  — reset, synchronous and active-high.
- req  in  NREQ  — per-requester write request (bit i = requester i).
- req_addr  in  5*NREQ  — requester i's register address in bits [5i+4:5i].
- req_data  in  32*NREQ  — requester i's write data in bits [32i+31:32i].
- gnt  out  NREQ  — one-hot grant, combinational, same cycle as acceptance.
- wr_en  out  1  — registered write-port enable.
- wr_addr  out  5  — registered write address; feeds the one-hot decoder's din.
- wr_data  out  32  — registered write data.
- conflict_cnt  out  CNT_W  — saturating count of cycles with more than one req bit high.

## Operation
- A transfer occurs at a rising edge where req[i] and gnt[i] are both high.
- A requester holds req, address and data stable until it sees gnt[i].
- A requester may not drop req before it is granted.
- gnt is all-zero when req is all-zero; otherwise exactly one bit is set.
- Selection is round-robin:
  - The winner is the first index j with req[j]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - After a transfer from index j, rr_ptr <= (j+1) mod NREQ.
  - With no transfer, rr_ptr holds its value.
- Output stage:
  - On a transfer, the next edge loads wr_en<=1, wr_addr<=req_addr[j] and wr_data<=req_data[j].
  - With no transfer, the next edge loads wr_en<=0; wr_addr and wr_data hold their last values.
- conflict_cnt increments on each edge where popcount(req)>=2 and saturates at 2^CNT_W-1 (no wrap).
- Reset values (rst high at an edge): wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0, conflict_cnt=0.
- gnt is forced to 0 while rst is high, so no transfer completes in the reset cycle.
- Reset mid-operation: an in-flight registered write is dropped (wr_en=0 after the edge). The requester whose grant was suppressed keeps req high and is served after reset.
- The same address from two requesters on consecutive grants produces two writes in grant order. The later write wins in the register file; no merging.

## Timing
- Request to gnt: 0 cycles (combinational from req and rr_ptr).
- Transfer to write-port valid: 1 cycle (wr_* registered).
- Throughput: one write per cycle, sustained.
- Fairness: a continuously asserted request is granted within NREQ cycles.
- Critical path is the NREQ-wide rotate-priority encoder plus the output mux. No combinational path exists from req_data to gnt.

## Configuration
- REGFILE_R0_ZERO_EN defined:
  - A granted request with address 5'd0 is still accepted (gnt pulses, rr_ptr advances).
  - The next edge loads wr_en<=0, so register 0 stays hard-wired to zero.
  - wr_addr and wr_data hold their previous values.
- REGFILE_R0_ZERO_EN undefined: address 0 is written like any other register.

## Test plan
- Reset: hold rst for 2 cycles with req=4'b1111 → gnt=0, wr_en=0, wr_addr=0, wr_data=0, conflict_cnt=0 throughout; first grant after release goes to requester 0.
- Single requester: req=4'b0100 with addr=5'd17 and data=32'hDEADBEEF → gnt=4'b0100 that cycle; next cycle wr_en=1, wr_addr=17, wr_data=32'hDEADBEEF; the following cycle wr_en=0.
- Round-robin: req=4'b1111 held for 8 cycles → gnt sequence 0001,0010,0100,1000,0001,…; conflict_cnt=8.
- Wrap and skip: rr_ptr=3, req=4'b0101 → grant 0 then 2; no idle cycle between them.
- R0 suppression: addr=0, data=32'h12345678 granted → with REGFILE_R0_ZERO_EN, wr_en stays 0; without it, wr_en=1 and wr_addr=0.
- Saturation and mid-reset: CNT_W=4 with 20 conflict cycles → conflict_cnt stops at 15. rst asserted the cycle after a grant → wr_en=0 after that edge and the requester is re-granted after release.
